ext_irq_arb: RTL and testbench

EXT_IRQ_ARB -- requirements
Module: ext_irq_arb

---
 rtl/ext_irq_arb_pkg.sv | 28 ++
 rtl/ext_irq_arb_pick.sv | 41 ++++
 rtl/ext_irq_arb.sv | 120 ++++++++++++
 tb/tb_ext_irq_arb.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ext_irq_arb_pkg.sv
// +----------------------------------------------------------------------+
// | ext_irq_arb_pkg : shared constants and types for the interrupt arbiter|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package ext_irq_arb_pkg;

  localparam int c_IRQ_NUM_DEF = 8;
  localparam int c_IDW_DEF     = 4;

  localparam logic [3:0] c_REG_PEND  = 4'd0;
  localparam logic [3:0] c_REG_EN    = 4'd1;
  localparam logic [3:0] c_REG_CLAIM = 4'd2;
  localparam logic [3:0] c_REG_CTRL  = 4'd3;

  localparam logic c_MODE_FIXED = 1'b0;
  localparam logic c_MODE_RR    = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_CLAIMED = 2'd2
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/ext_irq_arb_pick.sv
// +----------------------------------------------------------------------+
// | irq_pick : combinational winner search, fixed or round-robin wrap    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module irq_pick
  import ext_irq_arb_pkg::*;
#(
  parameter int IRQ_NUM = c_IRQ_NUM_DEF,
  parameter int IDW     = c_IDW_DEF
) (
  input  logic [IRQ_NUM-1:0] i_cand,
  input  logic [IDW-1:0]     i_start,
  input  logic               i_mode,
  output logic               o_found,
  output logic [IDW-1:0]     o_id
);

  int w_base;
  int w_idx;

  // Scan IRQ_NUM slots beginning at the start index; the first hit wins.
  always_comb begin
    o_found = 1'b0;
    o_id    = '0;
    w_idx   = 0;
    w_base  = (i_mode == c_MODE_RR) ? int'(i_start) : 0;
    for (int j = 0; j < IRQ_NUM; j++) begin
      w_idx = w_base + j;
      if (w_idx >= IRQ_NUM) w_idx = w_idx - IRQ_NUM;
      if (!o_found && i_cand[w_idx]) begin
        o_found = 1'b1;
        o_id    = IDW'(w_idx + 1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ext_irq_arb.sv
// +----------------------------------------------------------------------+
// | ext_irq_arb : edge-latched external interrupt arbiter, claim/complete|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module ext_irq_arb
  import ext_irq_arb_pkg::*;
#(
  parameter int IRQ_NUM = c_IRQ_NUM_DEF,
  parameter int IDW     = c_IDW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IRQ_NUM-1:0] irq_src_i,
  output logic               ex_trap_valid_o,
  input  logic               ex_trap_ready_i,
  input  logic               reg_we_i,
  input  logic [3:0]         reg_addr_i,
  input  logic [31:0]        reg_wdata_i,
  output logic [31:0]        reg_rdata_o,
  output logic [IDW-1:0]     claim_id_o
);

  localparam logic [IDW-1:0] c_LAST_RST = IDW'(IRQ_NUM - 1);

  arb_state_t         r_state, w_state_nxt;
  logic [IRQ_NUM-1:0] r_src_q, r_hold, r_pend, r_en;
  logic [IRQ_NUM-1:0] w_rise, w_clr, w_cand;
  logic               r_mode;
  logic [IDW-1:0]     r_req_id, r_claim_id, r_last;
  logic [IDW-1:0]     w_start, w_pick_id;
  logic               w_found, w_grant, w_complete;

  // r_hold masks sources seen high at reset until they drop, so a level
  // held through reset is not mistaken for a fresh edge.
  assign w_rise     = irq_src_i & ~r_src_q & ~r_hold;
  assign w_cand     = r_pend & r_en;
  assign w_grant    = (r_state == ST_REQ) && ex_trap_ready_i;
  assign w_complete = (r_state == ST_CLAIMED) && reg_we_i &&
                      (reg_addr_i == c_REG_CLAIM) &&
                      (reg_wdata_i[IDW-1:0] == r_claim_id);
  assign w_start    = (r_last == c_LAST_RST) ? '0 : r_last + IDW'(1);
  assign claim_id_o = r_claim_id;

  irq_pick #(
    .IRQ_NUM (IRQ_NUM),
    .IDW     (IDW)
  ) u_pick (
    .i_cand  (w_cand),
    .i_start (w_start),
    .i_mode  (r_mode),
    .o_found (w_found),
    .o_id    (w_pick_id)
  );

  always_comb begin
    w_clr = '0;
    for (int k = 0; k < IRQ_NUM; k++) begin
      if (w_grant && (r_req_id == IDW'(k + 1))) w_clr[k] = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    ex_trap_valid_o = 1'b0;
    unique case (r_state)
      ST_IDLE:    if (w_found) w_state_nxt = ST_REQ;
      ST_REQ: begin
        ex_trap_valid_o = 1'b1;
        if (ex_trap_ready_i) w_state_nxt = ST_CLAIMED;
      end
      ST_CLAIMED: if (w_complete) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_src_q    <= '0;
      r_hold     <= irq_src_i;
      r_pend     <= '0;
      r_en       <= '0;
      r_mode     <= c_MODE_FIXED;
      r_req_id   <= '0;
      r_claim_id <= '0;
      r_last     <= c_LAST_RST;
    end else begin
      r_state <= w_state_nxt;
      r_src_q <= irq_src_i;
      r_hold  <= r_hold & irq_src_i;
      // A new edge in the grant cycle re-sets the bit being cleared.
      r_pend  <= (r_pend & ~w_clr) | w_rise;
      if (reg_we_i && (reg_addr_i == c_REG_EN))   r_en   <= reg_wdata_i[IRQ_NUM-1:0];
      if (reg_we_i && (reg_addr_i == c_REG_CTRL)) r_mode <= reg_wdata_i[0];
      if ((r_state == ST_IDLE) && w_found) r_req_id <= w_pick_id;
      if (w_grant) begin
        r_claim_id <= r_req_id;
        r_last     <= r_req_id - IDW'(1);
      end else if (w_complete) begin
        r_claim_id <= '0;
      end
    end
  end

  always_comb begin
    reg_rdata_o = '0;
    case (reg_addr_i)
      c_REG_PEND:  reg_rdata_o = {{(32-IRQ_NUM){1'b0}}, r_pend};
      c_REG_EN:    reg_rdata_o = {{(32-IRQ_NUM){1'b0}}, r_en};
      c_REG_CLAIM: reg_rdata_o = {{(32-IDW){1'b0}}, r_claim_id};
      c_REG_CTRL:  reg_rdata_o = {31'd0, r_mode};
      default:     reg_rdata_o = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_ext_irq_arb.sv
// +----------------------------------------------------------------------+
// | tb_ext_irq_arb : scoreboard bench for the interrupt arbiter          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_ext_irq_arb;

  localparam int IRQ_NUM = 8;
  localparam int IDW     = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [IRQ_NUM-1:0] r_src;
  logic               w_valid;
  logic               r_ready;
  logic               r_we;
  logic [3:0]         r_addr;
  logic [31:0]        r_wdata;
  logic [31:0]        w_rdata;
  logic [IDW-1:0]     w_claim;

  int n_tests = 0;
  int n_fail  = 0;
  logic [IDW-1:0] r_exp_q[$];

  always #5 clk = ~clk;

  ext_irq_arb #(.IRQ_NUM(IRQ_NUM), .IDW(IDW)) dut (
    .clk             (clk),
    .rst             (rst),
    .irq_src_i       (r_src),
    .ex_trap_valid_o (w_valid),
    .ex_trap_ready_i (r_ready),
    .reg_we_i        (r_we),
    .reg_addr_i      (r_addr),
    .reg_wdata_i     (r_wdata),
    .reg_rdata_o     (w_rdata),
    .claim_id_o      (w_claim)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_wr(input logic [3:0] a, input logic [31:0] d);
    r_we = 1'b1; r_addr = a; r_wdata = d;
    tick();
    r_we = 1'b0; r_wdata = '0;
  endtask

  task automatic reg_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    r_addr = a;
    #1;
    check(tag, w_rdata, exp);
  endtask

  task automatic pulse(input logic [IRQ_NUM-1:0] m);
    r_src = r_src | m;
    tick();
    r_src = r_src & ~m;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20 && !w_valid; i++) tick();
    check(tag, {31'd0, w_valid}, 32'd1);
  endtask

  task automatic grant_chk(input string tag, output logic [IDW-1:0] exp);
    wait_valid({tag, "_valid"});
    exp = (r_exp_q.size() > 0) ? r_exp_q.pop_front() : '1;
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    check({tag, "_id"}, {28'd0, w_claim}, {28'd0, exp});
  endtask

  task automatic complete(input logic [IDW-1:0] id);
    reg_wr(4'd2, {28'd0, id});
    check("claim_clr", {28'd0, w_claim}, 32'd0);
  endtask

  task automatic serve(input string tag);
    logic [IDW-1:0] id;
    grant_chk(tag, id);
    complete(id);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IDW-1:0] id;
    rst = 1'b1; r_src = '0; r_ready = 1'b0; r_we = 1'b0; r_addr = '0; r_wdata = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_valid", {31'd0, w_valid}, 32'd0);
    check("rst_claim", {28'd0, w_claim}, 32'd0);
    for (int a = 0; a < 6; a++) reg_chk("rst_reg", 4'(a), 32'd0);

    // Fixed priority, simultaneous edges on sources 5 and 2
    reg_wr(4'd1, 32'hFF);
    reg_wr(4'd3, 32'h0);
    r_exp_q.push_back(4'd3); r_exp_q.push_back(4'd6);
    pulse(8'h24);
    check("lat_pend_novalid", {31'd0, w_valid}, 32'd0);
    reg_chk("pend_both", 4'd0, 32'h24);
    tick();
    check("lat_req", {31'd0, w_valid}, 32'd1);
    grant_chk("fixed1", id);
    reg_chk("pend_after1", 4'd0, 32'h20);
    check("claimed_novalid", {31'd0, w_valid}, 32'd0);
    complete(id);
    check("lat_next_idle", {31'd0, w_valid}, 32'd0);
    reg_chk("pend_before2", 4'd0, 32'h20);
    tick();
    check("lat_next_req", {31'd0, w_valid}, 32'd1);
    grant_chk("fixed2", id);
    reg_chk("pend_after2", 4'd0, 32'h0);
    complete(id);

    // Round-robin with wrap
    reg_wr(4'd3, 32'h1);
    reg_chk("ctrl_rd", 4'd3, 32'h1);
    reg_chk("en_rd", 4'd1, 32'hFF);
    r_exp_q.push_back(4'd3);
    pulse(8'h04);
    serve("rr_src2");
    r_exp_q.push_back(4'd7); r_exp_q.push_back(4'd2);
    pulse(8'h42);
    serve("rr_src6");
    serve("rr_wrap");
    reg_wr(4'd3, 32'h0);

    // Hold while requesting; disabling the latched source must not withdraw
    r_exp_q.push_back(4'd4); r_exp_q.push_back(4'd1);
    pulse(8'h08);
    wait_valid("hold_start");
    reg_wr(4'd1, 32'hF7);
    pulse(8'h01);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold_valid", {31'd0, w_valid}, 32'd1);
    end
    grant_chk("hold4", id);
    reg_chk("accum_pend", 4'd0, 32'h01);
    tick();
    check("claimed_block", {31'd0, w_valid}, 32'd0);
    complete(id);
    serve("hold_then1");
    reg_wr(4'd1, 32'hFF);

    // Bad complete
    r_exp_q.push_back(4'd3);
    pulse(8'h04);
    grant_chk("bad_cpl", id);
    reg_wr(4'd2, 32'd5);
    check("bad_cpl_claim", {28'd0, w_claim}, 32'd3);
    tick();
    check("bad_cpl_novalid", {31'd0, w_valid}, 32'd0);
    complete(4'd3);

    // Edge lands in the grant cycle of the same source
    r_exp_q.push_back(4'd4); r_exp_q.push_back(4'd4);
    pulse(8'h08);
    wait_valid("coll_start");
    r_src = r_src | 8'h08;
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    r_src = r_src & ~8'h08;
    id = (r_exp_q.size() > 0) ? r_exp_q.pop_front() : '1;
    check("coll_claim", {28'd0, w_claim}, {28'd0, id});
    reg_chk("coll_pend", 4'd0, 32'h08);
    complete(id);
    serve("coll_again");

    // Reset mid-REQ with a source held high across reset
    r_src = 8'h0A;
    tick();
    r_src = 8'h08;
    tick();
    check("mid_valid", {31'd0, w_valid}, 32'd1);
    reg_chk("mid_pend", 4'd0, 32'h0A);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_valid", {31'd0, w_valid}, 32'd0);
    check("rst2_claim", {28'd0, w_claim}, 32'd0);
    reg_chk("rst2_pend", 4'd0, 32'h0);
    reg_chk("rst2_en", 4'd1, 32'h0);
    reg_wr(4'd1, 32'hFF);
    for (int i = 0; i < 3; i++) tick();
    check("held_novalid", {31'd0, w_valid}, 32'd0);
    reg_chk("held_nopend", 4'd0, 32'h0);
    r_src = '0;
    tick();
    r_exp_q.push_back(4'd4);
    pulse(8'h08);
    serve("rerise");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
